clock_divider: RTL and testbench



---
 rtl/clock_divider_pkg.sv | 15 +
 rtl/clock_divider.sv | 58 +++++
 tb/tb_clock_divider.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/clock_divider_pkg.sv
// Shared helpers for clock_divider: derives the period and counter width
// from the clock frequency and requested output period.
package clock_divider_pkg;

  function automatic int calc_period(input int mhz, input int us);
    return mhz * us;
  endfunction

  function automatic int calc_cw(input int period);
    int cw;
    cw = $clog2(period);
    return (cw < 1) ? 1 : cw;
  endfunction

endpackage

// File: rtl/clock_divider.sv
// Microsecond timebase: registered square wave of period US_DELAY us.
// Optional one-cycle TICK strobe on each rising edge of out with CLOCK_DIVIDER_TICK_EN.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int CLOCK_SPEED_MHZ = 12,
  parameter int US_DELAY        = 2
) (
  input  logic CLK,
  input  logic RESET,
  output logic out
`ifdef CLOCK_DIVIDER_TICK_EN
  ,
  output logic TICK
`endif
);

  localparam int PERIOD = calc_period(CLOCK_SPEED_MHZ, US_DELAY);
  localparam int HIGH   = PERIOD / 2;
  localparam int LOW    = PERIOD - HIGH;
  localparam int CW     = calc_cw(PERIOD);

  if (PERIOD < 2) begin : g_period_check
    $error("clock_divider: PERIOD must be at least 2");
  end

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  always_comb begin
    count_nxt = count + CW'(1);
    if (count == CW'(PERIOD - 1)) begin
      count_nxt = '0;
    end
  end

  // out is decoded from count_nxt so the flop lands on the same edge as count.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
      out   <= 1'b0;
    end else begin
      count <= count_nxt;
      out   <= (count_nxt >= CW'(LOW));
    end
  end

`ifdef CLOCK_DIVIDER_TICK_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      TICK <= 1'b0;
    end else begin
      TICK <= (count_nxt == CW'(LOW));
    end
  end
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: three parameter sets sharing one clock and reset.
module tb_clock_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_a, out_b, out_c;
`ifdef CLOCK_DIVIDER_TICK_EN
  logic tick_a, tick_b, tick_c;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_divider #(.CLOCK_SPEED_MHZ(12), .US_DELAY(2)) u_a (
    .CLK(clk), .RESET(rst), .out(out_a)
`ifdef CLOCK_DIVIDER_TICK_EN
    , .TICK(tick_a)
`endif
  );

  clock_divider #(.CLOCK_SPEED_MHZ(3), .US_DELAY(1)) u_b (
    .CLK(clk), .RESET(rst), .out(out_b)
`ifdef CLOCK_DIVIDER_TICK_EN
    , .TICK(tick_b)
`endif
  );

  clock_divider #(.CLOCK_SPEED_MHZ(2), .US_DELAY(1)) u_c (
    .CLK(clk), .RESET(rst), .out(out_c)
`ifdef CLOCK_DIVIDER_TICK_EN
    , .TICK(tick_c)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // After k edges out of reset the counter holds k mod P; out is high once it reaches LOW.
  function automatic int exp_out(input int k, input int p);
    return ((k % p) >= (p - p / 2)) ? 1 : 0;
  endfunction

  function automatic int exp_tick(input int k, input int p);
    return ((k % p) == (p - p / 2)) ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input int k);
    check("out_a", out_a, exp_out(k, 24));
    check("out_b", out_b, exp_out(k, 3));
    check("out_c", out_c, exp_out(k, 2));
`ifdef CLOCK_DIVIDER_TICK_EN
    check("tick_a", tick_a, exp_tick(k, 24));
    check("tick_b", tick_b, exp_tick(k, 3));
    check("tick_c", tick_c, exp_tick(k, 2));
`endif
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_a"}, out_a, 0);
    check({tag, "_b"}, out_b, 0);
    check({tag, "_c"}, out_c, 0);
`ifdef CLOCK_DIVIDER_TICK_EN
    check({tag, "_tick_a"}, tick_a, 0);
    check({tag, "_tick_b"}, tick_b, 0);
    check({tag, "_tick_c"}, tick_c, 0);
`endif
  endtask

  // Runs n edges from release, checking the model and the rise timing of out_a.
  task automatic run_free(input int n, input int check_spacing);
    int first_rise = -1;
    int last_rise  = -1;
    int rises      = 0;
    logic prev_a   = 1'b0;
    for (int k = 1; k <= n; k++) begin
      step();
      check_model(k);
      if (!prev_a && out_a) begin
        rises++;
        if (first_rise < 0) first_rise = k;
        else if (check_spacing != 0) check("rise_spacing_a", k - last_rise, 24);
        last_rise = k;
      end
      if (prev_a && !out_a) check("fall_at_multiple_a", k % 24, 0);
      prev_a = out_a;
    end
    check("first_rise_a", first_rise, 12);
    if (check_spacing != 0) check("rise_count_a", rises, n / 24);
  endtask

  initial begin
    // Reset asserted from time 0, released between edges.
    step();
    step();
    check_all_low("reset");
    rst = 1'b0;

    // Ten full periods of the default divider, plus the small-period instances.
    run_free(240, 1);

    // Run into the high phase, then reset between edges.
    for (int k = 0; k < 15; k++) step();
    check("mid_high_before_reset", out_a, 1);
    #3;
    rst = 1'b1;
    #1;
    check_all_low("async_reset");

    // Hold reset for 100 cycles.
    for (int k = 0; k < 100; k++) begin
      step();
      check_all_low("held_reset");
    end
    #3;
    rst = 1'b0;

    run_free(30, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
